// File: rtl/mult_share_arbiter.sv
// Round-robin controller that time-shares one external combinational
// multiplier between two requesting channels. Operands are registered onto
// the multiplier inputs, the product is captured one cycle later and handed
// back to the owning channel together with a one-cycle done pulse.
module mult_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               grant0,
  output logic               grant1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] p0,
  output logic [2*WIDTH-1:0] p1,
  output logic               busy,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic               gnt_reg;         // channel that owns the current operation
  logic               last_grant_reg;  // channel served most recently
  logic               pick_next;       // channel to grant if a request is taken now
  logic [2*WIDTH-1:0] p0_reg;
  logic [2*WIDTH-1:0] p1_reg;
  logic [WIDTH-1:0]   mult_a_reg;
  logic [WIDTH-1:0]   mult_b_reg;

  // Round-robin choice: on contention the channel that was not served last wins
  always_comb begin
    pick_next = 1'b0;
    if (req0 && req1) begin
      pick_next = ~last_grant_reg;
    end else if (req1) begin
      pick_next = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: requests are only looked at from IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req0 || req1) state_next = MUL;
      MUL:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, operand latch and product capture
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      mult_a_reg     <= '0;
      mult_b_reg     <= '0;
      p0_reg         <= '0;
      p1_reg         <= '0;
    end else begin
      if (state_reg == IDLE && (req0 || req1)) begin
        gnt_reg        <= pick_next;
        last_grant_reg <= pick_next;
        mult_a_reg     <= pick_next ? a1 : a0;
        mult_b_reg     <= pick_next ? b1 : b0;
      end
      if (state_reg == MUL) begin
        if (gnt_reg) begin
          p1_reg <= mult_p;
        end else begin
          p0_reg <= mult_p;
        end
      end
    end
  end

  // Outputs decoded from the state and the owning channel
  always_comb begin
    grant0 = (state_reg != IDLE) && !gnt_reg;
    grant1 = (state_reg != IDLE) &&  gnt_reg;
    done0  = (state_reg == DONE) && !gnt_reg;
    done1  = (state_reg == DONE) &&  gnt_reg;
    busy   = (state_reg != IDLE);
  end

  assign p0     = p0_reg;
  assign p1     = p1_reg;
  assign mult_a = mult_a_reg;
  assign mult_b = mult_b_reg;

endmodule
